// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with phase FSMs, two-stage sync/blank pipeline.
// Optional VGA_BLANK_FORCE_EN forces RGBOut to black whenever the aligned blankN is low.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN,
  output logic [7:0]  RGBOut
);

  localparam logic [10:0] HVisLast = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HFpLast  = 11'(H_ACTIVE + H_FRONT - 1);
  localparam logic [10:0] HSyLast  = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] HTotLast = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] VVisLast = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VFpLast  = 11'(V_ACTIVE + V_FRONT - 1);
  localparam logic [10:0] VSyLast  = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] VTotLast = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  typedef enum logic [1:0] {HVis, HFp, HSy, HBp} h_state_e;
  typedef enum logic [1:0] {VVis, VFp, VSy, VBp} v_state_e;

  h_state_e    h_state_q, h_state_d;
  v_state_e    v_state_q, v_state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        run_q;
  logic        line_end;
  logic        vis_raw, hs_raw_n, vs_raw_n;
  logic        hs_s1_q, vs_s1_q, bl_s1_q;
  logic        hs_q, vs_q, bl_q;
  logic [7:0]  rgb_q, rgb_d;

  // run_q holds the counters at 0/0 for the first edge after reset release.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      run_q     <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      h_state_q <= HVis;
      v_state_q <= VVis;
    end else begin
      run_q     <= 1'b1;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  always_comb begin
    line_end  = run_q && (h_cnt_q == HTotLast);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;

    if (run_q) begin
      h_cnt_d = line_end ? 11'd0 : h_cnt_q + 11'd1;
      unique case (h_state_q)
        HVis: if (h_cnt_q == HVisLast) h_state_d = HFp;
        HFp:  if (h_cnt_q == HFpLast)  h_state_d = HSy;
        HSy:  if (h_cnt_q == HSyLast)  h_state_d = HBp;
        HBp:  if (h_cnt_q == HTotLast) h_state_d = HVis;
        default: h_state_d = HVis;
      endcase
    end

    if (line_end) begin
      v_cnt_d = (v_cnt_q == VTotLast) ? 11'd0 : v_cnt_q + 11'd1;
      unique case (v_state_q)
        VVis: if (v_cnt_q == VVisLast) v_state_d = VFp;
        VFp:  if (v_cnt_q == VFpLast)  v_state_d = VSy;
        VSy:  if (v_cnt_q == VSyLast)  v_state_d = VBp;
        VBp:  if (v_cnt_q == VTotLast) v_state_d = VVis;
        default: v_state_d = VVis;
      endcase
    end
  end

  // Raw decodes are held idle until counting starts so no phantom pixel enters the pipe.
  always_comb begin
    vis_raw  = run_q && (h_state_q == HVis) && (v_state_q == VVis);
    hs_raw_n = !(run_q && (h_state_q == HSy));
    vs_raw_n = !(run_q && (v_state_q == VSy));
  end

  always_comb begin
`ifdef VGA_BLANK_FORCE_EN
    rgb_d = bl_s1_q ? RGBIn : 8'h00;
`else
    rgb_d = RGBIn;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hs_s1_q <= 1'b1;
      vs_s1_q <= 1'b1;
      bl_s1_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      bl_q    <= 1'b0;
      rgb_q   <= 8'h00;
    end else begin
      hs_s1_q <= hs_raw_n;
      vs_s1_q <= vs_raw_n;
      bl_s1_q <= vis_raw;
      hs_q    <= hs_s1_q;
      vs_q    <= vs_s1_q;
      bl_q    <= bl_s1_q;
      rgb_q   <= rgb_d;
    end
  end

  assign pixelX       = h_cnt_q;
  assign pixelY       = v_cnt_q;
  assign startOfFrame = run_q && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  assign hSync        = hs_q;
  assign vSync        = vs_q;
  assign blankN       = bl_q;
  assign RGBOut       = rgb_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, meaning horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, meaning horizontal sync width in clocks.
REQ-004 Parameter H_BACK, default 48, meaning horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, meaning vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-009 clk  input  1  single pixel clock; all state on its rising edge.
REQ-010 resetN  input  1  asynchronous, active-low reset.
REQ-011 RGBIn  input  8  {R[2:0],G[2:0],B[1:0]} from the registered drawing blocks, valid one clock after pixelX/pixelY.
REQ-012 pixelX  output  11  current horizontal count, to drawing blocks.
REQ-013 pixelY  output  11  current vertical count, to drawing blocks.
REQ-014 startOfFrame  output  1  one-clock pulse while pixelX==0 and pixelY==0.
REQ-015 hSync  output  1  horizontal sync to DAC, active low.
REQ-016 vSync  output  1  vertical sync to DAC, active low.
REQ-017 blankN  output  1  high while the aligned pixel is visible.
REQ-018 RGBOut  output  8  registered pixel colour to DAC.

Function
REQ-019 Horizontal counter SHALL increment every clock from 0 to HT-1 (HT = sum of H parameters; 800 default) and wrap to 0.
REQ-020 Vertical counter SHALL increment only on the horizontal wrap, from 0 to VT-1 (525 default), and wrap to 0 on the horizontal wrap at VT-1.
REQ-021 Horizontal phase FSM states SHALL be H_VIS (0..H_ACTIVE-1), H_FP, H_SY, H_BP, advancing on phase-boundary counts; vertical FSM V_VIS, V_FP, V_SY, V_BP, advancing only at line wrap.
REQ-022 pixelX/pixelY SHALL be the raw registered counters, continuing through blanking (e.g. 640..799), so drawers see out-of-frame coordinates.
REQ-023 Sync decode: raw hSync low for counts H_ACTIVE+H_FRONT..+H_SYNC-1 (656..751); raw vSync low for lines 490..491; raw visible = H_VIS and V_VIS.
REQ-024 hSync, vSync, blankN SHALL pass through exactly two register stages, so they align with RGBOut, which registers RGBIn once; total latency counter->DAC outputs = 2 clocks.
REQ-025 startOfFrame SHALL be decoded from counters with zero added latency (same cycle as pixelX=0,pixelY=0).
REQ-026 Counter widths 11 bits; parameter sums exceeding 2047 are illegal (no behaviour required).

Reset
REQ-027 While resetN low: counters 0, FSMs H_VIS/V_VIS, hSync=1, vSync=1, blankN=0, RGBOut=0, startOfFrame=0, pipeline registers cleared to these values.
REQ-028 On resetN release mid-frame, first rising edge SHALL leave counters at 0/0 with startOfFrame=1; the next edge yields pixelX=1; no partial-frame state survives.

Configuration
REQ-029 Macro VGA_BLANK_FORCE_EN: when defined, RGBOut SHALL be 8'h00 whenever the aligned blankN is 0; when undefined, RGBOut SHALL be RGBIn registered unconditionally.

Verification
REQ-030 Reset hold then release -> pixelX=0,pixelY=0,startOfFrame=1 first cycle; hSync=vSync=1, RGBOut=0 until data propagates.
REQ-031 Run one line -> hSync low for exactly 96 clocks, first low 2 clocks after pixelX=656; pixelY 0->1 after pixelX=799.
REQ-032 Run full frame -> vSync low across lines 490-491 (2x800 clocks); at (799,524) next cycle (0,0) with startOfFrame pulse; exactly one pulse per 420000 clocks.
REQ-033 Drive RGBIn = pixelX[7:0] delayed one clock -> RGBOut equals 8'h05 exactly when blankN is high for pixel X=5; blankN rises 2 clocks after pixelX=0, falls 2 clocks after pixelX=640.
REQ-034 Assert resetN at (300,200) for 3 clocks -> outputs at reset values immediately; restart clean at (0,0).
REQ-035 Build with and without VGA_BLANK_FORCE_EN, RGBIn=8'hFF constant -> with: RGBOut=00 during blanking; without: RGBOut=FF always after reset.
